pmp_check_arbiter: RTL and testbench

Clocked arbiter that shares one PMP checker between two MMU requesters (r0 = instruction-side walker, r1 = data-side walker). It accepts at most one request at a time and forwards it to the checker. It returns the fault result to the owning requester and enforces a response timeout. It sits between the walkers and the PMP checker datapath, whose own fork/join handshaking stays unchanged behind `chk_*`.

---
 rtl/pmp_check_arbiter.sv | 132 +++++++++++++
 tb/tb_pmp_check_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pmp_check_arbiter.sv
// rtl/pmp_check_arbiter.sv - shares one PMP checker between the I-side and D-side walkers
// One request in flight; a response timeout forces a fault and marks the late result stale.
module pmp_check_arbiter #(
  parameter int ADDR_W  = 56,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [1:0]        r0_acc,
  input  logic [1:0]        r0_priv,
  output logic              r0_rsp_valid,
  output logic              r0_rsp_fault,
  output logic              r0_rsp_timeout,
  input  logic              r0_rsp_ready,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [1:0]        r1_acc,
  input  logic [1:0]        r1_priv,
  output logic              r1_rsp_valid,
  output logic              r1_rsp_fault,
  output logic              r1_rsp_timeout,
  input  logic              r1_rsp_ready,
  output logic              chk_valid,
  input  logic              chk_ready,
  output logic [ADDR_W-1:0] chk_addr,
  output logic [1:0]        chk_acc,
  output logic [1:0]        chk_priv,
  input  logic              chk_rsp_valid,
  input  logic              chk_rsp_fault,
  output logic              busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} stateT;

  stateT            state, stateNext;
  logic             owner, lastGrant, stale;
  logic             faultQ, timeoutQ;
  logic [CNT_W-1:0] cnt;
  logic             grant0, grant1, rspAccept, expire, rspTaken, discard;

  always_comb begin
    stateNext = state;
    grant0    = 1'b0;
    grant1    = 1'b0;
    rspAccept = 1'b0;
    expire    = 1'b0;
    rspTaken  = 1'b0;
    discard   = chk_rsp_valid && stale;
    case (state)
      IDLE: begin
        // On a tie the requester that did not win last time goes first.
        if (r0_valid && (!r1_valid || lastGrant)) grant0 = 1'b1;
        else if (r1_valid)                         grant1 = 1'b1;
        if (grant0 || grant1) stateNext = ISSUE;
      end
      ISSUE: if (chk_ready) stateNext = WAIT;
      WAIT: begin
        if (chk_rsp_valid && !stale) begin
          rspAccept = 1'b1;
          stateNext = RESP;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          expire    = 1'b1;
          stateNext = RESP;
        end
      end
      RESP: begin
        rspTaken = owner ? r1_rsp_ready : r0_rsp_ready;
        if (rspTaken) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner     <= 1'b0;
      lastGrant <= 1'b1;
      stale     <= 1'b0;
      faultQ    <= 1'b0;
      timeoutQ  <= 1'b0;
      cnt       <= '0;
      chk_addr  <= '0;
      chk_acc   <= '0;
      chk_priv  <= '0;
    end else begin
      if (grant0 || grant1) begin
        owner    <= grant1;
        chk_addr <= grant1 ? r1_addr : r0_addr;
        chk_acc  <= grant1 ? r1_acc  : r0_acc;
        chk_priv <= grant1 ? r1_priv : r0_priv;
      end
      if (state == ISSUE && chk_ready)
        cnt <= '0;
      else if (state == WAIT && !rspAccept && !(&cnt))
        cnt <= cnt + CNT_W'(1);
      if (rspAccept) begin
        faultQ   <= chk_rsp_fault;
        timeoutQ <= 1'b0;
      end else if (expire) begin
        faultQ   <= 1'b1;
        timeoutQ <= 1'b1;
      end
      // A fresh expiry outranks consuming the previous stale pulse.
      if (expire)       stale <= 1'b1;
      else if (discard) stale <= 1'b0;
      if (state == RESP && rspTaken) lastGrant <= owner;
    end
  end

  assign r0_ready       = grant0 && !rst;
  assign r1_ready       = grant1 && !rst;
  assign chk_valid      = (state == ISSUE);
  assign busy           = (state != IDLE);
  assign r0_rsp_valid   = (state == RESP) && !owner;
  assign r1_rsp_valid   = (state == RESP) && owner;
  assign r0_rsp_fault   = r0_rsp_valid && faultQ;
  assign r1_rsp_fault   = r1_rsp_valid && faultQ;
  assign r0_rsp_timeout = r0_rsp_valid && timeoutQ;
  assign r1_rsp_timeout = r1_rsp_valid && timeoutQ;

endmodule

// File: tb/tb_pmp_check_arbiter.sv
// tb/tb_pmp_check_arbiter.sv - randomized bench for pmp_check_arbiter against a transaction model
module tb_pmp_check_arbiter;
  localparam int ADDR_W  = 56;
  localparam int TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic r0_valid = 0, r1_valid = 0, r0_rsp_ready = 0, r1_rsp_ready = 0;
  logic [ADDR_W-1:0] r0_addr = '0, r1_addr = '0;
  logic [1:0] r0_acc = '0, r1_acc = '0, r0_priv = '0, r1_priv = '0;
  logic chk_ready = 0, chk_rsp_valid = 0, chk_rsp_fault = 0;
  logic r0_ready, r1_ready, r0_rsp_valid, r1_rsp_valid, r0_rsp_fault, r1_rsp_fault;
  logic r0_rsp_timeout, r1_rsp_timeout, chk_valid, busy;
  logic [ADDR_W-1:0] chk_addr;
  logic [1:0] chk_acc, chk_priv;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit lastGrantM = 1'b1;
  bit staleM = 1'b0;

  pmp_check_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_addr(r0_addr), .r0_acc(r0_acc), .r0_priv(r0_priv),
    .r0_rsp_valid(r0_rsp_valid), .r0_rsp_fault(r0_rsp_fault), .r0_rsp_timeout(r0_rsp_timeout),
    .r0_rsp_ready(r0_rsp_ready),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_addr(r1_addr), .r1_acc(r1_acc), .r1_priv(r1_priv),
    .r1_rsp_valid(r1_rsp_valid), .r1_rsp_fault(r1_rsp_fault), .r1_rsp_timeout(r1_rsp_timeout),
    .r1_rsp_ready(r1_rsp_ready),
    .chk_valid(chk_valid), .chk_ready(chk_ready), .chk_addr(chk_addr), .chk_acc(chk_acc),
    .chk_priv(chk_priv), .chk_rsp_valid(chk_rsp_valid), .chk_rsp_fault(chk_rsp_fault), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [ADDR_W-1:0] rndAddr();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[ADDR_W-1:0];
  endfunction

  // One full transaction. WAIT-phase pulses are given as indices counted from the
  // first WAIT cycle; spurAt carries fault=0, resAt carries resFault (-1 = no pulse).
  task automatic runTxn(input bit v0, input bit v1, input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                        input logic [1:0] acc0, input logic [1:0] acc1, input logic [1:0] pr0,
                        input logic [1:0] pr1, input int rdyDelay, input bit issuePulse,
                        input int spurAt, input int resAt, input bit resFault, input int rspHold);
    bit w, expFault, expTo, staleOut;
    int g, endIdx, lat;
    int pIdx[$];
    bit pF[$];
    logic [ADDR_W-1:0] expAddr;
    logic [1:0] expAcc, expPriv;

    w = (v0 && v1) ? !lastGrantM : !v0;
    expAddr = w ? a1 : a0;
    expAcc  = w ? acc1 : acc0;
    expPriv = w ? pr1 : pr0;
    r0_valid = v0; r1_valid = v1;
    r0_addr = a0; r1_addr = a1; r0_acc = acc0; r1_acc = acc1; r0_priv = pr0; r1_priv = pr1;
    r0_rsp_ready = w; r1_rsp_ready = !w;
    #1;
    checkEq("grant0", r0_ready, !w);
    checkEq("grant1", r1_ready, w);
    g = cyc;
    tick();
    if (w) r1_valid = 0; else r0_valid = 0;

    for (int k = 0; k <= rdyDelay; k++) begin
      chk_ready = (k == rdyDelay);
      chk_rsp_valid = issuePulse && (k == 0);
      chk_rsp_fault = 0;
      #1;
      checkEq("chkValid", chk_valid, 1);
      checkEq("chkAddr", chk_addr, expAddr);
      checkEq("chkAcc", chk_acc, expAcc);
      checkEq("chkPriv", chk_priv, expPriv);
      checkEq("issueBusy", busy, 1);
      checkEq("issueNoGrant", r0_ready | r1_ready, 0);
      tick();
    end
    chk_ready = 0; chk_rsp_valid = 0;
    if (issuePulse) staleM = 0;

    if (spurAt >= 0) begin pIdx.push_back(spurAt); pF.push_back(1'b0); end
    if (resAt >= 0)  begin pIdx.push_back(resAt);  pF.push_back(resFault); end
    if (staleM && pIdx.size() > 0) begin
      void'(pIdx.pop_front());
      void'(pF.pop_front());
    end
    if (pIdx.size() > 0) begin
      endIdx = pIdx[0]; expFault = pF[0]; expTo = 0; staleOut = 0;
    end else begin
      endIdx = TIMEOUT - 1; expFault = 1; expTo = 1; staleOut = 1;
    end

    for (int n = 0; n <= TIMEOUT + 2; n++) begin
      if (r0_rsp_valid || r1_rsp_valid) break;
      if (n == 0) checkEq("waitChkValid", chk_valid, 0);
      chk_rsp_valid = (n == spurAt) || (n == resAt);
      chk_rsp_fault = (n == resAt) && resFault;
      tick();
      chk_rsp_valid = 0; chk_rsp_fault = 0;
    end
    checkEq("rspSeen", r0_rsp_valid | r1_rsp_valid, 1);
    lat = cyc - g;
    checkEq("latency", lat, 3 + rdyDelay + endIdx);

    for (int h = 0; h <= rspHold; h++) begin
      if (w) r1_rsp_ready = (h == rspHold); else r0_rsp_ready = (h == rspHold);
      #1;
      checkEq("rspValidOwn", w ? r1_rsp_valid : r0_rsp_valid, 1);
      checkEq("rspOther", w ? (r0_rsp_valid | r0_rsp_fault | r0_rsp_timeout)
                            : (r1_rsp_valid | r1_rsp_fault | r1_rsp_timeout), 0);
      checkEq("rspFault", w ? r1_rsp_fault : r0_rsp_fault, expFault);
      checkEq("rspTimeout", w ? r1_rsp_timeout : r0_rsp_timeout, expTo);
      checkEq("respNoGrant", r0_ready | r1_ready, 0);
      tick();
    end
    checkEq("idleBusy", busy, 0);
    checkEq("idleRsp", r0_rsp_valid | r1_rsp_valid, 0);
    r0_valid = 0; r1_valid = 0; r0_rsp_ready = 0; r1_rsp_ready = 0;
    lastGrantM = w;
    staleM = staleOut;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int sel, rd, sp, ra;
    bit ip;

    r0_valid = 1; r1_valid = 1;
    #12;
    checkEq("rstReady", r0_ready | r1_ready, 0);
    checkEq("rstChkValid", chk_valid, 0);
    checkEq("rstBusy", busy, 0);
    checkEq("rstRsp", {r0_rsp_valid, r0_rsp_fault, r0_rsp_timeout, r1_rsp_valid, r1_rsp_fault, r1_rsp_timeout}, 0);
    checkEq("rstChkFields", {chk_addr, chk_acc, chk_priv}, 0);
    r0_valid = 0; r1_valid = 0;
    tick();
    rst = 0;

    runTxn(1, 0, 56'h80001000, rndAddr(), 2'b01, 2'b10, 2'b11, 2'b00, 0, 0, -1, 0, 0, 0);

    for (int i = 0; i < 4; i++)
      runTxn(1, 1, rndAddr(), rndAddr(), 2'(i), 2'(3 - i), 2'b01, 2'b10, 0, 0, -1, 0, 1'(i & 1), 0);

    runTxn(0, 1, rndAddr(), rndAddr(), 2'b00, 2'b01, 2'b00, 2'b11, 5, 0, -1, 1, 1, 3);
    runTxn(1, 0, rndAddr(), rndAddr(), 2'b10, 2'b00, 2'b01, 2'b00, 1, 1, -1, 1, 1, 0);

    runTxn(1, 0, rndAddr(), rndAddr(), 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, -1, -1, 0, 0);
    runTxn(0, 1, rndAddr(), rndAddr(), 2'b01, 2'b01, 2'b01, 2'b01, 0, 0, 0, 2, 1, 0);

    runTxn(1, 0, rndAddr(), rndAddr(), 2'b11, 2'b00, 2'b10, 2'b00, 0, 0, -1, TIMEOUT - 1, 0, 0);
    runTxn(1, 0, rndAddr(), rndAddr(), 2'b01, 2'b00, 2'b10, 2'b00, 0, 0, -1, 0, 1, 0);

    r0_valid = 1; r0_addr = rndAddr();
    #1;
    tick();
    r0_valid = 0; chk_ready = 1;
    tick();
    chk_ready = 0;
    tick();
    checkEq("midWaitBusy", busy, 1);
    r0_valid = 1; r1_valid = 1; rst = 1;
    #1;
    checkEq("midRstReady", r0_ready | r1_ready, 0);
    checkEq("midRstOut", {chk_valid, busy, r0_rsp_valid, r0_rsp_fault, r0_rsp_timeout,
                          r1_rsp_valid, r1_rsp_fault, r1_rsp_timeout}, 0);
    checkEq("midRstFields", {chk_addr, chk_acc, chk_priv}, 0);
    tick();
    rst = 0;
    #1;
    checkEq("postRstTie0", r0_ready, 1);
    checkEq("postRstTie1", r1_ready, 0);
    lastGrantM = 1; staleM = 0;
    runTxn(1, 1, rndAddr(), rndAddr(), 2'b01, 2'b10, 2'b00, 2'b11, 0, 0, -1, 1, 0, 1);

    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(2, 0);
      rd  = $urandom_range(3, 0);
      ip  = ($urandom_range(3, 0) == 0);
      ra  = ($urandom_range(4, 0) == 0) ? -1 : int'($urandom_range(TIMEOUT - 1, 0));
      sp  = -1;
      if ($urandom_range(2, 0) == 0) begin
        if (ra < 0)      sp = $urandom_range(TIMEOUT - 1, 0);
        else if (ra > 0) sp = $urandom_range(ra - 1, 0);
      end
      runTxn(sel != 1, sel != 0, rndAddr(), rndAddr(), 2'($urandom), 2'($urandom), 2'($urandom),
             2'($urandom), rd, ip, sp, ra, 1'($urandom), $urandom_range(2, 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
